fpu_wb_merge: RTL and testbench
===============================

Name: fpu_wb_merge

Overview:
- Per-lane merge stage directly upstream of the writeback stage.
- Collects FPU results from units of different latency: fdiv (4 clk), fadd/fsub/fmul/fsqrt (2 clk), ftoi/itof (1 clk).
- Buffers same-cycle collisions in a multi-push FIFO and presents one ordered GPR write per cycle to writeback.
- Exports a pending-register mask so issue logic can detect RAW hazards on buffered writes.

Parameters:
- NUM_SRC, 7, number of FPU result sources. Index 0 is the oldest-issued (longest latency); higher indices are younger.
- DEPTH, 8, FIFO entries; must be ≥ NUM_SRC.
- CNT_W, 4, count width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- interlock  in  1  pipeline stall; holds the output and blocks pop.
- res_valid  in  NUM_SRC  per-source result valid (rt_flag).
- res_rt  in  NUM_SRC*5  per-source destination register; source i occupies bits [5i+4:5i].
- res_data  in  NUM_SRC*32  per-source result; source i occupies bits [32i+31:32i].
- wb_rt_flag  out  1  write valid to writeback.
- wb_rt  out  5  write destination.
- wb_tdata  out  32  write data.
- almost_full  out  1  asserted when count ≥ DEPTH−NUM_SRC; issue must stop new FPU ops.
- overflow  out  1  sticky error flag.
- pending  out  32  bit r set when a buffered or presented write targets register r.

Behaviour:
- Reset (rst=1 at a clock edge): wb_rt_flag=0, wb_rt=0, wb_tdata=0, count=0, FIFO pointers=0, overflow=0. Reset wins over every other event; in-flight entries are discarded.
- Push:
  - Each cycle, every source with res_valid=1 and res_rt≠0 is pushed in ascending index order.
  - Sources with rt=0 are dropped, because r0 is not writable.
  - Pushes are accepted regardless of interlock.
- Head selection:
  - The logical queue is the FIFO contents followed by this cycle's pushes.
  - The head is the oldest FIFO entry if count>0; otherwise it is the lowest-index valid source this cycle.
- Pop (interlock=0):
  - If the logical queue is non-empty, the head is registered onto wb_rt/wb_tdata with wb_rt_flag=1 and is consumed.
  - If the queue is empty, wb_rt_flag=0, and wb_rt/wb_tdata hold their previous values.
- Latency: a result arriving at an empty queue with interlock=0 appears on wb_* exactly 1 cycle later.
- Bypass: when the head is a same-cycle input, that input is not written into the FIFO. The remaining pushes are written in order.
- Interlock=1: wb_* registers hold, and no pop occurs. count increases by the number of accepted pushes.
- Count update: count_next = count + pushes − pop, computed with CNT_W+1 bit arithmetic. Pointers wrap modulo DEPTH.
- Full:
  - If count + pushes − pop > DEPTH, the highest-index excess pushes are dropped.
  - overflow is set and stays set until rst.
  - Surviving entries keep their order.
- Ordering: writes to the same rt leave in push order. The later (younger) value is the last written to the GPR.
- pending:
  - Combinational OR over all valid FIFO entries plus (wb_rt_flag ? wb_rt : none).
  - Bit 0 is always 0.
  - Same-cycle inputs are not included.
- almost_full is combinational from registered count.

Test Plan:
- Single result: res_valid[3]=1, rt=5, data=0x3F800000 at cycle 0 on an empty queue, interlock=0 → at cycle 1 wb_rt_flag=1, wb_rt=5, wb_tdata=0x3F800000. At cycle 2 wb_rt_flag=0, and pending[5] goes 1→0.
- Collision: sources 0, 2 and 5 valid in the same cycle with rt=1/2/3 → wb outputs rt 1, 2, 3 on three consecutive cycles. count peaks at 2, then returns to 0.
- Interlock: queue holds rt=7 and rt=8 while interlock is held 3 cycles and source 1 pushes rt=9 → wb_* is frozen and count=3. After release, outputs appear in order 7, 8, 9.
- Overflow: DEPTH=8 with count=6 under interlock, then 4 pushes (rt 10..13) → rt 10 and 11 are kept, 12 and 13 are dropped. overflow=1 persists until rst, and almost_full=1.
- rt=0 and same-rt ordering: source 0 pushes rt=4, data=A and source 6 pushes rt=4, data=B in the same cycle, while source 2 pushes rt=0 → exactly two writes occur, A then B. The rt=0 entry is never emitted.
- Reset mid-operation: assert rst with count=5 and wb_rt_flag=1 → next cycle all outputs are 0, pending=0, and overflow=0. A new push 1 cycle after reset is emitted normally.

Source files
------------

// File: rtl/fpu_wb_merge.sv
// Merges FPU results from units of different latency into one ordered GPR write per cycle,
// buffering same-cycle collisions in a multi-push FIFO and exporting a pending-register mask.
module fpu_wb_merge #(
   parameter int NUM_SRC = 7,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   interlock,
   input  logic [NUM_SRC-1:0]     res_valid,
   input  logic [NUM_SRC*5-1:0]   res_rt,
   input  logic [NUM_SRC*32-1:0]  res_data,
   output logic                   wb_rt_flag,
   output logic [4:0]             wb_rt,
   output logic [31:0]            wb_tdata,
   output logic                   almost_full,
   output logic                   overflow,
   output logic [31:0]            pending
);

   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);
   localparam logic [CNT_W:0] ONE_C   = (CNT_W+1)'(1);
   localparam logic [CNT_W:0] AF_C    = (CNT_W+1)'(DEPTH - NUM_SRC);

   logic [4:0]         mem_rt   [DEPTH];
   logic [31:0]        mem_data [DEPTH];
   logic [CNT_W-1:0]   count, rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   rd_ptr_next, wr_ptr_next;
   logic [CNT_W:0]     count_next, room, n_acc, n_wr;
   logic [NUM_SRC-1:0] push_ok, wr_en;
   logic [CNT_W-1:0]   wr_idx [NUM_SRC];
   logic               pop, bypass, drop;
   logic [4:0]         head_rt;
   logic [31:0]        head_data;

   // Operands never exceed 2*DEPTH-1, so one conditional subtraction is a full modulo.
   function automatic logic [CNT_W-1:0] wrap(input logic [CNT_W:0] sum);
      return (sum >= DEPTH_C) ? CNT_W'(sum - DEPTH_C) : CNT_W'(sum);
   endfunction

   // NOTE: every variable in a combinational block gets a default before any conditional
   // assignment, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++)
         push_ok[i] = res_valid[i] && (res_rt[5*i +: 5] != 5'd0);

      head_rt   = '0;
      head_data = '0;
      for (int i = NUM_SRC-1; i >= 0; i--) begin
         if (push_ok[i]) begin
            head_rt   = res_rt[5*i +: 5];
            head_data = res_data[32*i +: 32];
         end
      end
      if (count != '0) begin
         head_rt   = mem_rt[rd_ptr];
         head_data = mem_data[rd_ptr];
      end

      pop    = !interlock && ((count != '0) || (push_ok != '0));
      bypass = pop && (count == '0);
      room   = DEPTH_C - {1'b0, count} + (pop ? ONE_C : '0);

      // The first accepted push is the head when bypassing, so it never lands in storage.
      n_acc = '0;
      n_wr  = '0;
      drop  = 1'b0;
      wr_en = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         wr_idx[i] = '0;
         if (push_ok[i]) begin
            if (n_acc < room) begin
               if (!(bypass && n_acc == '0)) begin
                  wr_en[i]  = 1'b1;
                  wr_idx[i] = wrap({1'b0, wr_ptr} + n_wr);
                  n_wr      = n_wr + ONE_C;
               end
               n_acc = n_acc + ONE_C;
            end else begin
               drop = 1'b1;
            end
         end
      end

      count_next  = {1'b0, count} + n_acc - (pop ? ONE_C : '0);
      wr_ptr_next = wrap({1'b0, wr_ptr} + n_wr);
      rd_ptr_next = (pop && !bypass) ? wrap({1'b0, rd_ptr} + ONE_C) : rd_ptr;
   end

   // NOTE: the storage array has no reset; count and the pointers alone define which
   // entries are live, so stale contents are never observed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (wr_en[i]) begin
            mem_rt[wr_idx[i]]   <= res_rt[5*i +: 5];
            mem_data[wr_idx[i]] <= res_data[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_rt_flag <= 1'b0;
         wb_rt      <= '0;
         wb_tdata   <= '0;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         overflow   <= 1'b0;
      end else begin
         count  <= count_next[CNT_W-1:0];
         rd_ptr <= rd_ptr_next;
         wr_ptr <= wr_ptr_next;
         if (drop)
            overflow <= 1'b1;
         if (pop) begin
            wb_rt_flag <= 1'b1;
            wb_rt      <= head_rt;
            wb_tdata   <= head_data;
         end else if (!interlock) begin
            wb_rt_flag <= 1'b0;
         end
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (wrap((CNT_W+1)'(i) + DEPTH_C - {1'b0, rd_ptr}) < count)
            pending[mem_rt[i]] = 1'b1;
      end
      if (wb_rt_flag)
         pending[wb_rt] = 1'b1;
      pending[0] = 1'b0;
   end

   assign almost_full = ({1'b0, count} >= AF_C);

endmodule

// File: tb/tb_fpu_wb_merge.sv
// Directed bench for fpu_wb_merge: a table of per-cycle vectors plus hand-written
// sequences for interlock, overflow and mid-operation reset.
module tb_fpu_wb_merge;

   localparam int NUM_SRC = 7;
   localparam int DEPTH   = 8;
   localparam int CNT_W   = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  interlock;
   logic [NUM_SRC-1:0]    res_valid;
   logic [NUM_SRC*5-1:0]  res_rt;
   logic [NUM_SRC*32-1:0] res_data;
   logic                  wb_rt_flag;
   logic [4:0]            wb_rt;
   logic [31:0]           wb_tdata;
   logic                  almost_full;
   logic                  overflow;
   logic [31:0]           pending;

   int n_checks = 0;
   int n_errors = 0;

   fpu_wb_merge #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .interlock   (interlock),
      .res_valid   (res_valid),
      .res_rt      (res_rt),
      .res_data    (res_data),
      .wb_rt_flag  (wb_rt_flag),
      .wb_rt       (wb_rt),
      .wb_tdata    (wb_tdata),
      .almost_full (almost_full),
      .overflow    (overflow),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      string                       name;
      logic [NUM_SRC-1:0]          valid;
      logic [NUM_SRC-1:0][4:0]     rt;
      logic [NUM_SRC-1:0][31:0]    data;
      logic                        e_flag;
      logic [4:0]                  e_rt;
      logic [31:0]                 e_data;
      logic [31:0]                 e_pend;
      logic                        e_af;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_all(input string name, input logic flag, input logic [4:0] r,
                             input logic [31:0] d, input logic [31:0] pend,
                             input logic af, input logic ovf);
      check({name, ".flag"}, 32'(wb_rt_flag), 32'(flag));
      check({name, ".rt"},   32'(wb_rt),      32'(r));
      check({name, ".data"}, wb_tdata,        d);
      check({name, ".pend"}, pending,         pend);
      check({name, ".af"},   32'(almost_full), 32'(af));
      check({name, ".ovf"},  32'(overflow),   32'(ovf));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_src();
      res_valid = '0;
      res_rt    = '0;
      res_data  = '0;
   endtask

   task automatic set_src(input int i, input logic [4:0] r, input logic [31:0] d);
      res_valid[i]        = 1'b1;
      res_rt[5*i +: 5]    = r;
      res_data[32*i +: 32] = d;
   endtask

   function automatic logic [31:0] bits(input int lo, input int hi);
      logic [31:0] m = '0;
      for (int b = lo; b <= hi; b++) m[b] = 1'b1;
      return m;
   endfunction

   function automatic vec_t nv(input string name, input logic fl, input logic [4:0] r,
                               input logic [31:0] d, input logic [31:0] p, input logic af);
      vec_t v;
      v.name = name;  v.valid = '0;  v.rt = '0;  v.data = '0;
      v.e_flag = fl;  v.e_rt = r;    v.e_data = d;  v.e_pend = p;  v.e_af = af;
      return v;
   endfunction

   initial begin
      vec_t v;
      logic [4:0]  exp_rt   [8];
      logic [31:0] exp_data [8];

      // Table: inputs applied before an edge, expected outputs just after it.
      v = nv("single_in", 1, 5, 32'h3F80_0000, 32'h0000_0020, 0);
      v.valid[3] = 1; v.rt[3] = 5; v.data[3] = 32'h3F80_0000; vecs.push_back(v);
      vecs.push_back(nv("single_out", 0, 5, 32'h3F80_0000, 32'h0, 0));
      v = nv("coll_1", 1, 1, 32'h11, 32'h0000_000E, 1);
      v.valid[0] = 1; v.rt[0] = 1; v.data[0] = 32'h11;
      v.valid[2] = 1; v.rt[2] = 2; v.data[2] = 32'h22;
      v.valid[5] = 1; v.rt[5] = 3; v.data[5] = 32'h33; vecs.push_back(v);
      vecs.push_back(nv("coll_2", 1, 2, 32'h22, 32'h0000_000C, 1));
      vecs.push_back(nv("coll_3", 1, 3, 32'h33, 32'h0000_0008, 0));
      vecs.push_back(nv("coll_idle", 0, 3, 32'h33, 32'h0, 0));
      v = nv("same_rt_a", 1, 4, 32'hAAAA_0000, 32'h0000_0010, 1);
      v.valid[0] = 1; v.rt[0] = 4; v.data[0] = 32'hAAAA_0000;
      v.valid[2] = 1; v.rt[2] = 0; v.data[2] = 32'hDEAD_BEEF;
      v.valid[6] = 1; v.rt[6] = 4; v.data[6] = 32'hBBBB_0000; vecs.push_back(v);
      vecs.push_back(nv("same_rt_b", 1, 4, 32'hBBBB_0000, 32'h0000_0010, 0));
      vecs.push_back(nv("same_rt_idle", 0, 4, 32'hBBBB_0000, 32'h0, 0));

      rst = 1'b1;
      interlock = 1'b0;
      clear_src();
      tick();
      tick();
      expect_all("reset", 0, 0, 32'h0, 32'h0, 0, 0);
      rst = 1'b0;

      foreach (vecs[k]) begin
         res_valid = vecs[k].valid;
         res_rt    = vecs[k].rt;
         res_data  = vecs[k].data;
         tick();
         expect_all(vecs[k].name, vecs[k].e_flag, vecs[k].e_rt, vecs[k].e_data,
                    vecs[k].e_pend, vecs[k].e_af, 0);
      end
      clear_src();

      // Interlock: outputs frozen while three entries accumulate, then drained in order.
      interlock = 1'b1;
      set_src(0, 7, 32'h70);
      set_src(3, 8, 32'h80);
      tick();
      expect_all("il_push", 0, 4, 32'hBBBB_0000, bits(7, 8), 1, 0);
      clear_src();
      set_src(1, 9, 32'h90);
      tick();
      expect_all("il_push2", 0, 4, 32'hBBBB_0000, bits(7, 9), 1, 0);
      clear_src();
      tick();
      expect_all("il_hold", 0, 4, 32'hBBBB_0000, bits(7, 9), 1, 0);
      interlock = 1'b0;
      tick();
      expect_all("il_out7", 1, 7, 32'h70, bits(7, 9), 1, 0);
      tick();
      expect_all("il_out8", 1, 8, 32'h80, bits(8, 9), 1, 0);
      tick();
      expect_all("il_out9", 1, 9, 32'h90, bits(9, 9), 0, 0);
      tick();
      expect_all("il_idle", 0, 9, 32'h90, 32'h0, 0, 0);

      // Overflow: six entries buffered, four more pushed with room for only two.
      interlock = 1'b1;
      for (int i = 0; i < 6; i++) set_src(i, 5'(20 + i), 32'h100 + 32'(i));
      tick();
      expect_all("ovf_fill", 0, 9, 32'h90, bits(20, 25), 1, 0);
      clear_src();
      for (int i = 0; i < 4; i++) set_src(i, 5'(10 + i), 32'h200 + 32'(i));
      tick();
      expect_all("ovf_push", 0, 9, 32'h90, bits(20, 25) | bits(10, 11), 1, 1);
      clear_src();
      interlock = 1'b0;
      for (int i = 0; i < 6; i++) begin
         exp_rt[i]   = 5'(20 + i);
         exp_data[i] = 32'h100 + 32'(i);
      end
      exp_rt[6] = 10;  exp_data[6] = 32'h200;
      exp_rt[7] = 11;  exp_data[7] = 32'h201;
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("ovf_drain%0d.flag", k), 32'(wb_rt_flag), 32'd1);
         check($sformatf("ovf_drain%0d.rt", k),   32'(wb_rt),      32'(exp_rt[k]));
         check($sformatf("ovf_drain%0d.data", k), wb_tdata,        exp_data[k]);
      end
      tick();
      expect_all("ovf_idle", 0, 11, 32'h201, 32'h0, 0, 1);

      // Reset mid-operation: one write presented and five buffered.
      set_src(0, 14, 32'hE0);
      tick();
      clear_src();
      interlock = 1'b1;
      for (int i = 0; i < 5; i++) set_src(i, 5'(15 + i), 32'h300 + 32'(i));
      tick();
      expect_all("pre_rst", 1, 14, 32'hE0, bits(14, 19), 1, 1);
      clear_src();
      rst = 1'b1;
      interlock = 1'b0;
      tick();
      expect_all("rst_mid", 0, 0, 32'h0, 32'h0, 0, 0);
      rst = 1'b0;
      tick();
      expect_all("rst_idle", 0, 0, 32'h0, 32'h0, 0, 0);
      set_src(4, 21, 32'h2121);
      tick();
      expect_all("post_rst", 1, 21, 32'h2121, bits(21, 21), 0, 0);
      clear_src();
      tick();
      expect_all("post_rst_idle", 0, 21, 32'h2121, 32'h0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
